// File: rtl/dfd_cla_pkg.sv
// Shared CLA definitions: cross-trigger channel indices, default action-bus bit
// positions and the per-channel self-filter status record.
package dfd_cla_pkg;

  localparam int XTRIG_CH0 = 0;
  localparam int XTRIG_CH1 = 1;
  localparam int XTRIG_CH2 = 2;
  localparam int XTRIG_CH3 = 3;

  localparam int DEFAULT_XTRIG_ACTION_BASE = 8;
  localparam int DEFAULT_HALT_ACTION_IDX   = 0;

  // Wide enough for FILTER_DEPTH up to 128.
  localparam int FILTER_OCC_W = 8;

  typedef struct packed {
    logic                    ovf;
    logic [FILTER_OCC_W-1:0] occupancy;
  } filter_status_t;

endpackage

// File: rtl/dfd_cla_self_filter_fifo.sv
// One cross-trigger channel: timestamp FIFO of in-flight self launches; the head
// pops (and masks the returning trigger) once its age reaches the loop delay.
module dfd_cla_self_filter_fifo
  import dfd_cla_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            launch,
  input  logic [TS_W-1:0] loop_delay,
  input  logic [TS_W-1:0] now,
  output logic            self_filter,
  output logic            ovf
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [TS_W-1:0]  age;
  filter_status_t   status_q, status_d;
  logic             empty, full, pop, push, drop, delayed;

  assign empty   = (status_q.occupancy == '0);
  assign full    = (status_q.occupancy == FILTER_OCC_W'(DEPTH));
  assign age     = now - ts_mem[rd_ptr];
  assign pop     = !empty && (age >= loop_delay);
  assign delayed = launch && (loop_delay != '0);
  // A pop frees a slot in the same cycle, so full+pop still accepts the push.
  assign push    = delayed && (!full || pop);
  assign drop    = delayed && full && !pop;

  assign self_filter = pop || (launch && (loop_delay == '0));
  assign ovf         = status_q.ovf;

  always_comb begin
    status_d           = status_q;
    status_d.ovf       = status_q.ovf | drop;
    status_d.occupancy = status_q.occupancy + FILTER_OCC_W'(push) - FILTER_OCC_W'(pop);
  end

  tt_dfd_generic_dff #(.WIDTH($bits(filter_status_t))) u_status (
    .clock(clock), .reset(reset), .en(1'b1), .d(status_d), .q(status_q)
  );

  tt_dfd_generic_dff #(.WIDTH(PTR_W)) u_rd_ptr (
    .clock(clock), .reset(reset), .en(pop), .d(rd_ptr + PTR_W'(1)), .q(rd_ptr)
  );

  tt_dfd_generic_dff #(.WIDTH(PTR_W)) u_wr_ptr (
    .clock(clock), .reset(reset), .en(push), .d(wr_ptr + PTR_W'(1)), .q(wr_ptr)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    tt_dfd_generic_dff #(.WIDTH(TS_W)) u_ts (
      .clock(clock), .reset(reset), .en(push && (wr_ptr == PTR_W'(k))),
      .d(now), .q(ts_mem[k])
    );
  end

endmodule

// File: rtl/tt_dfd_generic_dff.sv
// Generic enabled flop bank with synchronous active-high clear.
module tt_dfd_generic_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dfd_cla_xtrig_action_gen.sv
// CLA action generator: EAP node tracking, registered action bus, cross-trigger
// launch with per-channel self-filtering, sticky clock-halt.
// Optional DFD_CLA_XTRIG_FILTER_CNT_EN adds per-channel saturating self_filter hit counters.
module dfd_cla_xtrig_action_gen
  import dfd_cla_pkg::*;
#(
  parameter int NUM_NODES         = 4,
  parameter int NUM_ACTIONS       = 32,
  parameter int NUM_XTRIG         = 4,
  parameter int XTRIG_ACTION_BASE = DEFAULT_XTRIG_ACTION_BASE,
  parameter int HALT_ACTION_IDX   = DEFAULT_HALT_ACTION_IDX,
  parameter int LOOP_DLY_W        = 7,
  parameter int FILTER_DEPTH      = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   enable_eap,
  input  logic [NUM_NODES*NUM_ACTIONS-1:0]       node_action_bus,
  input  logic [NUM_NODES*$clog2(NUM_NODES)-1:0] node_dest_id,
  input  logic [NUM_XTRIG*LOOP_DLY_W-1:0]        loop_delay,
  input  logic                                   halt_en,
  input  logic                                   halt_clear,
  output logic [$clog2(NUM_NODES)-1:0]           current_node_id,
  output logic [NUM_ACTIONS-1:0]                 action_bus,
  output logic [NUM_XTRIG-1:0]                   xtrigger_out,
  output logic [NUM_XTRIG-1:0]                   self_filter,
  output logic [NUM_XTRIG-1:0]                   filter_ovf,
  output logic                                   clock_halt
`ifdef DFD_CLA_XTRIG_FILTER_CNT_EN
  ,
  output logic [NUM_XTRIG*16-1:0]                filter_hit_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_NODES);

  logic [ID_W-1:0]        node_next;
  logic [NUM_ACTIONS-1:0] action_next;
  logic [LOOP_DLY_W-1:0]  now;
  logic                   halt_next;

  always_comb begin
    node_next   = '0;
    action_next = '0;
    if (enable_eap) begin
      node_next   = node_dest_id[current_node_id*ID_W +: ID_W];
      action_next = node_action_bus[current_node_id*NUM_ACTIONS +: NUM_ACTIONS];
    end
  end

  // Set has priority over a simultaneous clear.
  assign halt_next = (action_bus[HALT_ACTION_IDX] && halt_en) ? 1'b1 :
                     (halt_clear ? 1'b0 : clock_halt);

  assign xtrigger_out = action_bus[XTRIG_ACTION_BASE +: NUM_XTRIG];

  tt_dfd_generic_dff #(.WIDTH(ID_W)) u_node (
    .clock(clock), .reset(reset), .en(1'b1), .d(node_next), .q(current_node_id)
  );

  tt_dfd_generic_dff #(.WIDTH(NUM_ACTIONS)) u_action (
    .clock(clock), .reset(reset), .en(1'b1), .d(action_next), .q(action_bus)
  );

  tt_dfd_generic_dff #(.WIDTH(LOOP_DLY_W)) u_now (
    .clock(clock), .reset(reset), .en(1'b1), .d(now + LOOP_DLY_W'(1)), .q(now)
  );

  tt_dfd_generic_dff #(.WIDTH(1)) u_halt (
    .clock(clock), .reset(reset), .en(1'b1), .d(halt_next), .q(clock_halt)
  );

  for (genvar i = 0; i < NUM_XTRIG; i++) begin : g_chan
    dfd_cla_self_filter_fifo #(.DEPTH(FILTER_DEPTH), .TS_W(LOOP_DLY_W)) u_filter (
      .clock      (clock),
      .reset      (reset),
      .launch     (xtrigger_out[i]),
      .loop_delay (loop_delay[i*LOOP_DLY_W +: LOOP_DLY_W]),
      .now        (now),
      .self_filter(self_filter[i]),
      .ovf        (filter_ovf[i])
    );

`ifdef DFD_CLA_XTRIG_FILTER_CNT_EN
    logic [15:0] hit_cnt;
    tt_dfd_generic_dff #(.WIDTH(16)) u_hit_cnt (
      .clock(clock), .reset(reset), .en(self_filter[i] && (hit_cnt != 16'hFFFF)),
      .d(hit_cnt + 16'd1), .q(hit_cnt)
    );
    assign filter_hit_cnt[i*16 +: 16] = hit_cnt;
`endif
  end

endmodule

// File: tb/tb_dfd_cla_xtrig_action_gen.sv
// Directed bench for dfd_cla_xtrig_action_gen: node/halt vector table plus
// per-channel self-filter sequences.
module tb_dfd_cla_xtrig_action_gen;
  import dfd_cla_pkg::*;

  localparam int NN = 4;
  localparam int NA = 32;
  localparam int NX = 4;
  localparam int W  = 7;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable_eap;
  logic [NN*NA-1:0]  node_action_bus;
  logic [NN*2-1:0]   node_dest_id;
  logic [NX*W-1:0]   loop_delay;
  logic              halt_en;
  logic              halt_clear;
  logic [1:0]        current_node_id;
  logic [NA-1:0]     action_bus;
  logic [NX-1:0]     xtrigger_out;
  logic [NX-1:0]     self_filter;
  logic [NX-1:0]     filter_ovf;
  logic              clock_halt;
`ifdef DFD_CLA_XTRIG_FILTER_CNT_EN
  logic [NX*16-1:0]  filter_hit_cnt;
`endif

  dfd_cla_xtrig_action_gen #(
    .NUM_NODES(NN), .NUM_ACTIONS(NA), .NUM_XTRIG(NX), .XTRIG_ACTION_BASE(8),
    .HALT_ACTION_IDX(0), .LOOP_DLY_W(W), .FILTER_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .enable_eap(enable_eap),
    .node_action_bus(node_action_bus), .node_dest_id(node_dest_id),
    .loop_delay(loop_delay), .halt_en(halt_en), .halt_clear(halt_clear),
    .current_node_id(current_node_id), .action_bus(action_bus),
    .xtrigger_out(xtrigger_out), .self_filter(self_filter),
    .filter_ovf(filter_ovf), .clock_halt(clock_halt)
`ifdef DFD_CLA_XTRIG_FILTER_CNT_EN
    , .filter_hit_cnt(filter_hit_cnt)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int launches[$];
  int pulses[$];

  typedef struct {
    logic        en;
    logic        hen;
    logic        hclr;
    logic [1:0]  cur;
    logic [31:0] act;
    logic [3:0]  xt;
    logic [3:0]  sf;
    logic        halt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    node_action_bus = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic bit is_launch(input int c);
    foreach (launches[k]) if (launches[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_pulse(input int c);
    foreach (pulses[k]) if (pulses[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Cycle 0 is the first cycle after reset release; timestamp now == cycle number (mod 128).
  task automatic run_chan(input string name, input int ch, input int ncyc, input int dly,
                          input int ovf_at, input int chg_cyc, input int chg_dly);
    loop_delay               = '0;
    loop_delay[ch*W +: W]    = W'(dly);
    node_dest_id             = '0;
    enable_eap               = 1'b1;
    halt_en                  = 1'b0;
    halt_clear               = 1'b0;
    do_reset();
    check($sformatf("%s sf c0", name), self_filter, 0);
    check($sformatf("%s ovf c0", name), filter_ovf, 0);
    for (int c = 0; c < ncyc; c++) begin
      node_action_bus = '0;
      if (is_launch(c + 1)) node_action_bus[8 + ch] = 1'b1;
      step();
      if (c + 1 == chg_cyc) begin
        loop_delay[ch*W +: W] = W'(chg_dly);
        #1;
      end
      check($sformatf("%s sf c%0d", name, c + 1), self_filter[ch], is_pulse(c + 1));
      check($sformatf("%s ovf c%0d", name, c + 1), filter_ovf[ch],
            (ovf_at >= 0) && (c + 1 > ovf_at));
    end
    node_action_bus = '0;
  endtask

  initial begin
    // Node walk 0->1->2->3->0, halt set/clear priority, enable_eap gating.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0100, 4'b0001, 4'b0001, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0002, 4'b0000, 4'b0000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd3, 32'h0000_0201, 4'b0010, 4'b0010, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0001, 4'b0000, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_0100, 4'b0001, 4'b0001, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0000_0002, 4'b0000, 4'b0000, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0100, 4'b0001, 4'b0001, 1'b0};

    enable_eap      = 1'b0;
    halt_en         = 1'b0;
    halt_clear      = 1'b0;
    loop_delay      = '0;
    node_action_bus = {32'h0000_0001, 32'h0000_0201, 32'h0000_0002, 32'h0000_0100};
    node_dest_id    = {2'd0, 2'd3, 2'd2, 2'd1};
    reset           = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst node", current_node_id, 0);
    check("rst action", action_bus, 0);
    check("rst xtrig", xtrigger_out, 0);
    check("rst sf", self_filter, 0);
    check("rst ovf", filter_ovf, 0);
    check("rst halt", clock_halt, 0);

    for (int r = 0; r < 9; r++) begin
      enable_eap = tbl[r].en;
      halt_en    = tbl[r].hen;
      halt_clear = tbl[r].hclr;
      step();
      check($sformatf("row%0d node", r), current_node_id, tbl[r].cur);
      check($sformatf("row%0d action", r), action_bus, tbl[r].act);
      check($sformatf("row%0d xtrig", r), xtrigger_out, tbl[r].xt);
      check($sformatf("row%0d sf", r), self_filter, tbl[r].sf);
      check($sformatf("row%0d halt", r), clock_halt, tbl[r].halt);
    end

    launches = '{10};             pulses = '{15};
    run_chan("echo", XTRIG_CH0, 25, 5, -1, -1, 0);

    launches = '{10, 12, 13};     pulses = '{30, 32, 33};
    run_chan("burst", XTRIG_CH1, 40, 20, -1, -1, 0);

    launches = '{10, 11, 12, 13, 14}; pulses = '{60, 61, 62, 63};
    run_chan("ovf", XTRIG_CH2, 70, 50, 14, -1, 0);

    launches = '{5};              pulses = '{5};
    run_chan("dly0", XTRIG_CH3, 10, 0, -1, -1, 0);

    launches = '{120};            pulses = '{247};
    run_chan("wrap", XTRIG_CH3, 250, 127, -1, -1, 0);

    launches = '{5, 6, 7, 10};    pulses = '{9, 10, 11};
    run_chan("dlychg", XTRIG_CH0, 20, 10, -1, 9, 0);

    launches = '{10, 12};         pulses = {};
    run_chan("midrst", XTRIG_CH1, 15, 20, -1, -1, 0);
    launches = {};                pulses = {};
    run_chan("postrst", XTRIG_CH1, 40, 20, -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
